button_events: RTL and testbench

- Input-side front end for the blink control path. Converts the raw active-low push-buttons button_0 and button_1 into clean single-cycle events that control logic consumes.
- Per button it synchronises, debounces and runs a small press-tracking FSM. Outputs are press/release pulses, a long-press pulse and a held level.
- The two button channels are fully independent.

---
 rtl/button_events_pkg.sv | 13 +
 rtl/button_channel.sv | 134 +++++++++++++
 rtl/button_events.sv | 44 ++++
 tb/tb_button_events.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/button_events_pkg.sv
// rtl/button_events_pkg.sv - shared state encoding and defaults for the button front end
package button_events_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } btn_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int LONG_CYCLES_DEF     = 64;

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - synchroniser, debouncer and press-tracking FSM for one button
module button_channel
   import button_events_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic held
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LONG_CYCLES + 1);

   logic          sync_a;
   logic          sync_b;
   logic          sync_pressed;
   logic          deb_pressed;
   logic [DW-1:0] deb_cnt;
   logic          diff;
   logic          hit;
   logic          rise;
   logic          fall;

   btn_state_t    state;
   btn_state_t    state_n;
   logic [LW-1:0] lcnt;
   logic [LW-1:0] lcnt_n;
   logic          press_n;
   logic          release_n;
   logic          long_n;

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= button;
         sync_b <= sync_a;
      end
   end

   assign sync_pressed = ~sync_b;

   // Flip decision: the level has disagreed for the full window on this edge.
   always_comb begin
      diff = (sync_pressed != deb_pressed);
      hit  = diff && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
      rise = hit &&  sync_pressed;
      fall = hit && !sync_pressed;
   end

   // Debounce counter: runs while the level disagrees, flips state at the threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_pressed <= 1'b0;
         deb_cnt     <= '0;
      end else if (!diff) begin
         deb_cnt     <= '0;
      end else if (hit) begin
         deb_pressed <= ~deb_pressed;
         deb_cnt     <= '0;
      end else begin
         deb_cnt     <= deb_cnt + DW'(1);
      end
   end

   // FSM state, long counter and registered event pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         lcnt          <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         state         <= state_n;
         lcnt          <= lcnt_n;
         press         <= press_n;
         release_pulse <= release_n;
         long_press    <= long_n;
      end
   end

   // Next state and pulses; a release on the long-threshold edge wins over long_press.
   always_comb begin
      state_n   = state;
      lcnt_n    = lcnt;
      press_n   = 1'b0;
      release_n = 1'b0;
      long_n    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n = PRESSED;
               press_n = 1'b1;
               lcnt_n  = '0;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_n   = IDLE;
               release_n = 1'b1;
            end else begin
               if (lcnt != LW'(LONG_CYCLES)) begin
                  lcnt_n = lcnt + LW'(1);
               end
               if (lcnt == LW'(LONG_CYCLES - 1)) begin
                  state_n = LONG;
                  long_n  = 1'b1;
               end
            end
         end
         LONG: begin
            if (fall) begin
               state_n   = IDLE;
               release_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign held = (state == PRESSED) || (state == LONG);

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - two independent debounced button channels producing event pulses
module button_events
   import button_events_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_0,
   input  logic       button_1,
   output logic [1:0] press,
   output logic [1:0] release_pulse,
   output logic [1:0] long_press,
   output logic [1:0] held
);

   button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) u_ch0 (
      .clk           (clk),
      .rst           (rst),
      .button        (button_0),
      .press         (press[0]),
      .release_pulse (release_pulse[0]),
      .long_press    (long_press[0]),
      .held          (held[0])
   );

   button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) u_ch1 (
      .clk           (clk),
      .rst           (rst),
      .button        (button_1),
      .press         (press[1]),
      .release_pulse (release_pulse[1]),
      .long_press    (long_press[1]),
      .held          (held[1])
   );

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - scoreboard bench for button_events against a history-window model
module tb_button_events;

   localparam int D = 4;
   localparam int L = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       button_0 = 1'b1;
   logic       button_1 = 1'b1;
   logic [1:0] press;
   logic [1:0] release_pulse;
   logic [1:0] long_press;
   logic [1:0] held;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic [1:0] p;
      logic [1:0] r;
      logic [1:0] l;
   } ev_t;

   ev_t        evq[$];
   logic [1:0] exp_held = 2'b00;

   // Model state: raw-sample history (bit k = raw pressed at edge cyc-k), debounced level, press time.
   logic [15:0] hist [2];
   logic        deb [2];
   int          press_at [2];
   logic        long_done [2];

   button_events dut (
      .clk           (clk),
      .rst           (rst),
      .button_0      (button_0),
      .button_1      (button_1),
      .press         (press),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .held          (held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         hist[b]      = '0;
         deb[b]       = 1'b0;
         press_at[b]  = 0;
         long_done[b] = 1'b0;
      end
      exp_held = 2'b00;
   endtask

   // The debounced level flips once the synchronised level (raw delayed two edges)
   // has disagreed with it on D consecutive edges.
   task automatic model_step();
      ev_t  e;
      logic raw_p;
      logic flip;
      e.cyc = cyc;
      e.p   = 2'b00;
      e.r   = 2'b00;
      e.l   = 2'b00;
      for (int b = 0; b < 2; b++) begin
         raw_p   = (b == 0) ? ~button_0 : ~button_1;
         hist[b] = {hist[b][14:0], raw_p};
         flip    = 1'b1;
         for (int k = 2; k <= D + 1; k++) begin
            if (hist[b][k] == deb[b]) flip = 1'b0;
         end
         if (flip) begin
            deb[b] = ~deb[b];
            if (deb[b]) begin
               e.p[b]       = 1'b1;
               press_at[b]  = cyc;
               long_done[b] = 1'b0;
            end else begin
               e.r[b] = 1'b1;
            end
         end else if (deb[b] && !long_done[b] && (cyc - press_at[b] == L)) begin
            e.l[b]       = 1'b1;
            long_done[b] = 1'b1;
         end
         exp_held[b] = deb[b];
      end
      if ((e.p | e.r | e.l) != 2'b00) evq.push_back(e);
   endtask

   // Reference model, advanced on every rising edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) model_reset();
         else     model_step();
      end
   end

   // Monitor: compares held every cycle and pops an expected event whenever pulses appear.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_outputs", {24'd0, press, release_pulse, long_press, held}, 32'd0);
         end else begin
            chk("held", {30'd0, held}, {30'd0, exp_held});
            if ((press | release_pulse | long_press) != 2'b00 ||
                (evq.size() > 0 && evq[0].cyc <= cyc)) begin
               if (evq.size() == 0) begin
                  chk("unexpected_pulse", {26'd0, press, release_pulse, long_press}, 32'd0);
               end else begin
                  e = evq.pop_front();
                  chk("event_cycle", cyc, e.cyc);
                  chk("event_value", {26'd0, press, release_pulse, long_press},
                      {26'd0, e.p, e.r, e.l});
               end
            end
         end
      end
   end

   task automatic apply(input logic v0, input logic v1, input int n);
      button_0 = v0;
      button_1 = v1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int rem0;
      int rem1;
      rst = 1'b1;
      #12;
      chk("reset_hold", {24'd0, press, release_pulse, long_press, held}, 32'd0);
      #8;
      rst = 1'b0;

      // Idle, short press, glitches, alternating toggles
      apply(1, 1, 200);
      apply(0, 1, 5);
      apply(1, 1, 30);
      apply(1, 0, 3);
      apply(1, 1, 20);
      for (int i = 0; i < 40; i++) apply(1, i[0], 1);
      apply(1, 1, 20);

      // Long press, then concurrent press with staggered release
      apply(1, 0, 100);
      apply(1, 1, 30);
      apply(0, 0, 20);
      apply(1, 0, 2);
      apply(1, 1, 30);

      // Reset while button_0 is held, release of reset with button still down
      apply(0, 1, 20);
      #2 rst = 1'b1;
      #1 chk("async_reset", {24'd0, press, release_pulse, long_press, held}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      apply(0, 1, 20);
      apply(1, 1, 30);

      // Random independent activity on both buttons
      rem0 = 1;
      rem1 = 1;
      for (int i = 0; i < 3000; i++) begin
         rem0--;
         rem1--;
         if (rem0 == 0) begin
            button_0 = ~button_0;
            rem0 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 90);
         end
         if (rem1 == 0) begin
            button_1 = ~button_1;
            rem1 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 90);
         end
         @(negedge clk);
      end

      apply(1, 1, 30);
      chk("queue_drained", evq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
